// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable RAM family.
package ram_pkg;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_e;

  // Widest word any byte-enable memory may use with be_merge.
  localparam int MAX_BE_W = 32;

  typedef logic [MAX_BE_W*8-1:0] word_max_t;
  typedef logic [MAX_BE_W-1:0]   be_max_t;

  // Replace each byte of old_w whose enable bit is set with the matching byte of new_w.
  function automatic word_max_t be_merge(input word_max_t old_w,
                                         input word_max_t new_w,
                                         input be_max_t   be);
    word_max_t res;
    res = old_w;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Post-reset clear sweep: walks every address once, writing zero, then parks in READY.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int NUM_WORDS  = 256,
  parameter int ADDR_W     = $clog2(NUM_WORDS),
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              init_busy_o,
  output logic              init_we_o,
  output logic [ADDR_W-1:0] init_addr_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  init_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= (INIT_CLEAR != 0) ? INIT : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_we_o   = 1'b0;
    init_busy_o = 1'b0;
    case (state_q)
      INIT: begin
        init_we_o   = 1'b1;
        init_busy_o = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY:   state_d = READY;
      default: state_d = READY;
    endcase
  end

  assign init_addr_o = cnt_q;

endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte enables, 1/2-cycle read latency, read-valid strobe,
// selectable read-during-write policy and optional post-reset clear sweep.
module ram_sdp_be
  import ram_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_WORDS  = 256,
  parameter int ADDR_W     = $clog2(NUM_WORDS),
  parameter int BE_W       = DATA_W / 8,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              init_busy
);

  if (DATA_W % 8 != 0 || DATA_W > MAX_BE_W * 8) begin : g_bad_data_w
    $error("ram_sdp_be: DATA_W must be a multiple of 8 and at most %0d", MAX_BE_W * 8);
  end
  if (BE_W != DATA_W / 8) begin : g_bad_be_w
    $error("ram_sdp_be: BE_W must equal DATA_W/8");
  end
  if (NUM_WORDS < 2 || ADDR_W < $clog2(NUM_WORDS)) begin : g_bad_depth
    $error("ram_sdp_be: NUM_WORDS must be >= 2 and fit in ADDR_W");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("ram_sdp_be: RD_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
    $error("ram_sdp_be: RDW_MODE must be 0 or 1");
  end

  localparam rdw_mode_e       RDW   = (RDW_MODE != 0) ? RDW_WRITE_FIRST : RDW_READ_FIRST;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(NUM_WORDS);

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;

  ram_init_seq #(
    .NUM_WORDS  (NUM_WORDS),
    .ADDR_W     (ADDR_W),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_init_seq (
    .clk_i       (clk),
    .rst_i       (rst),
    .init_busy_o (init_busy),
    .init_we_o   (init_we),
    .init_addr_o (init_addr)
  );

  logic ready, wr_in_range, rd_in_range, user_we, rd_fire, collide;

  assign ready       = ~init_busy;
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH);
  assign user_we     = ready & wr_en & wr_in_range;
  assign rd_fire     = ready & rd_en;
  assign collide     = rd_fire & user_we & (rd_addr == wr_addr);

  // The clear sweep owns the write port while it runs; user traffic is ignored.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;

  always_comb begin
    mem_we    = user_we;
    mem_addr  = wr_addr;
    mem_wdata = wr_data;
    mem_be    = wr_be;
    if (init_we) begin
      mem_we    = 1'b1;
      mem_addr  = init_addr;
      mem_wdata = '0;
      mem_be    = '1;
    end
  end

  logic [DATA_W-1:0] mem_q [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_be[i]) mem_q[mem_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      end
    end
  end

  logic [DATA_W-1:0] rd_old, rd_word;

  assign rd_old = rd_in_range ? mem_q[rd_addr] : '0;

  always_comb begin
    rd_word = rd_old;
    if (RDW == RDW_WRITE_FIRST && collide) begin
      rd_word = DATA_W'(be_merge(word_max_t'(rd_old), word_max_t'(wr_data), be_max_t'(wr_be)));
    end
  end

  // Stage 1 only loads on a read so rd_data holds between strobes.
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_fire;
      if (rd_fire) s1_data_q <= rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic              s2_valid_q;
    logic [DATA_W-1:0] s2_data_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_data_q  <= s1_data_q;
      end
    end

    assign rd_valid = s2_valid_q;
    assign rd_data  = s2_data_q;
  end else begin : g_lat1
    assign rd_valid = s1_valid_q;
    assign rd_data  = s1_data_q;
  end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench for ram_sdp_be: three configurations share one stimulus stream and are
// checked every cycle against an array/queue-level model plus literal expectations.
module tb_ram_sdp_be;

  localparam int NI = 3;
  localparam int NW_T  [NI] = '{16, 16, 12};
  localparam int LAT_T [NI] = '{1, 2, 2};
  localparam int RDW_T [NI] = '{1, 0, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic [NI-1:0]    rdv, busy;
  logic [NI*32-1:0] rdd;

  always #5 clk = ~clk;

  ram_sdp_be #(.DATA_W(32), .NUM_WORDS(16), .RD_LATENCY(1), .RDW_MODE(1), .INIT_CLEAR(1)) u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[31:0]), .rd_valid(rdv[0]), .init_busy(busy[0]));

  ram_sdp_be #(.DATA_W(32), .NUM_WORDS(16), .RD_LATENCY(2), .RDW_MODE(0), .INIT_CLEAR(1)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[63:32]), .rd_valid(rdv[1]), .init_busy(busy[1]));

  ram_sdp_be #(.DATA_W(32), .NUM_WORDS(12), .RD_LATENCY(2), .RDW_MODE(1), .INIT_CLEAR(1)) u_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[95:64]), .rd_valid(rdv[2]), .init_busy(busy[2]));

  always @(posedge clk) begin
    if (!rst) begin
      assert (!((wr_en && $isunknown(wr_addr)) || (rd_en && $isunknown(rd_addr))))
        else $error("FAIL x_addr: unknown address with an enable high");
    end
  end

  // Model state
  logic [31:0] m_mem    [NI][16];
  int          sweep_left [NI];
  logic        m_prev_v [NI];
  logic [31:0] m_prev_d [NI];
  logic        m_out_v  [NI];
  logic [31:0] m_out_d  [NI];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  function automatic logic [31:0] rdd_of(int i);
    return rdd[i*32 +: 32];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      sweep_left[i] = NW_T[i];
      m_prev_v[i]   = 1'b0;
      m_prev_d[i]   = '0;
      m_out_v[i]    = 1'b0;
      m_out_d[i]    = '0;
    end
  endtask

  // Predict the effect of the coming edge, take it, then compare every instance.
  task automatic cycle();
    logic        v_new;
    logic [31:0] d_new;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        sweep_left[i] = NW_T[i];
        m_prev_v[i] = 1'b0;
        m_out_v[i]  = 1'b0;
        m_out_d[i]  = '0;
      end else begin
        v_new = 1'b0;
        d_new = '0;
        if (sweep_left[i] > 0) begin
          m_mem[i][NW_T[i] - sweep_left[i]] = '0;
          sweep_left[i]--;
        end else begin
          if (rd_en) begin
            v_new = 1'b1;
            d_new = (int'(rd_addr) < NW_T[i]) ? m_mem[i][rd_addr] : 32'h0;
            if (RDW_T[i] == 1 && wr_en && wr_addr == rd_addr && int'(wr_addr) < NW_T[i])
              d_new = merge(d_new, wr_data, wr_be);
          end
          if (wr_en && int'(wr_addr) < NW_T[i])
            m_mem[i][wr_addr] = merge(m_mem[i][wr_addr], wr_data, wr_be);
        end
        if (LAT_T[i] == 1) begin
          m_out_v[i] = v_new;
          if (v_new) m_out_d[i] = d_new;
        end else begin
          m_out_v[i] = m_prev_v[i];
          if (m_prev_v[i]) m_out_d[i] = m_prev_d[i];
        end
        m_prev_v[i] = v_new;
        m_prev_d[i] = d_new;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rd_valid[%0d]", i), 32'(rdv[i]), 32'(m_out_v[i]));
      chk($sformatf("rd_data[%0d]", i), rdd_of(i), m_out_d[i]);
      chk($sformatf("init_busy[%0d]", i), 32'(busy[i]), 32'(rst || sweep_left[i] > 0));
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_be = '0; wr_data = '0; wr_addr = '0;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  task automatic do_write(int a, logic [31:0] d, logic [3:0] be);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d; wr_be = be;
  endtask

  task automatic do_read(int a);
    rd_en = 1'b1; rd_addr = 4'(a);
  endtask

  // Assert rst between edges and confirm outputs clear without waiting for a clock.
  task automatic async_reset(string tag);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_rd_valid[%0d]", tag, i), 32'(rdv[i]), 32'h0);
      chk($sformatf("%s_rd_data[%0d]", tag, i), rdd_of(i), 32'h0);
      chk($sformatf("%s_busy[%0d]", tag, i), 32'(busy[i]), 32'h1);
    end
    model_reset();
  endtask

  initial begin
    int hi_a, hi_c;
    logic        lat_v [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] lat_d [5] = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h3};

    idle();
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_rd_valid[%0d]", i), 32'(rdv[i]), 32'h0);
      chk($sformatf("rst_rd_data[%0d]", i), rdd_of(i), 32'h0);
      chk($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'h1);
    end
    cycle();
    cycle();
    rst = 1'b0;

    // Clear sweep, with reads requested while it runs
    hi_a = 0; hi_c = 0;
    for (int k = 0; k < 20; k++) begin
      idle();
      if (k < 10) do_read(k);
      hi_a += int'(busy[0]);
      hi_c += int'(busy[2]);
      cycle();
    end
    chk("sweep_len_a", 32'(hi_a), 32'd16);
    chk("sweep_len_c", 32'(hi_c), 32'd12);
    for (int a = 0; a < 16; a++) begin
      idle(); do_read(a); cycle();
    end
    idle(); cycle(); cycle();

    // Byte enables
    do_write(5, 32'hAABBCCDD, 4'hF); cycle();
    do_write(5, 32'h11223344, 4'b0101); cycle();
    idle(); do_read(5); cycle();
    chk("lit_be_a", rdd_of(0), 32'hAA22CC44);
    idle(); cycle();
    chk("lit_be_b", rdd_of(1), 32'hAA22CC44);

    // Latency and pipelining
    for (int a = 1; a <= 3; a++) begin
      idle(); do_write(a, 32'(a), 4'hF); cycle();
    end
    idle(); cycle();
    for (int k = 0; k < 5; k++) begin
      idle();
      if (k < 3) do_read(k + 1);
      cycle();
      chk($sformatf("lit_lat_v%0d", k), 32'(rdv[1]), 32'(lat_v[k]));
      if (k >= 1) chk($sformatf("lit_lat_d%0d", k), rdd_of(1), lat_d[k]);
    end

    // Read-during-write collision
    idle(); do_write(7, 32'hFFFFFFFF, 4'b0011); do_read(7); cycle();
    chk("lit_col_a", rdd_of(0), 32'h0000FFFF);
    idle(); cycle();
    chk("lit_col_b", rdd_of(1), 32'h00000000);
    chk("lit_col_c", rdd_of(2), 32'h0000FFFF);
    idle(); do_read(7); cycle();
    chk("lit_col2_a", rdd_of(0), 32'h0000FFFF);
    idle(); cycle();
    chk("lit_col2_b", rdd_of(1), 32'h0000FFFF);

    // Out-of-range on the 12-word instance
    idle(); do_write(13, 32'h5A5A5A5A, 4'hF); cycle();
    idle(); do_read(13); cycle();
    idle(); cycle();
    chk("lit_oor_v", 32'(rdv[2]), 32'h1);
    chk("lit_oor_d", rdd_of(2), 32'h0);
    for (int a = 0; a < 12; a++) begin
      idle(); do_read(a); cycle();
    end
    idle(); cycle(); cycle();

    // Reset with a read in flight, then reset again mid-sweep
    idle(); do_read(5); cycle();
    async_reset("inflight");
    idle(); cycle();
    rst = 1'b0;
    for (int k = 0; k < 9; k++) cycle();
    async_reset("midsweep");
    cycle();
    rst = 1'b0;
    hi_a = 0; hi_c = 0;
    for (int k = 0; k < 20; k++) begin
      hi_a += int'(busy[0]);
      hi_c += int'(busy[2]);
      cycle();
    end
    chk("restart_len_a", 32'(hi_a), 32'd16);
    chk("restart_len_c", 32'(hi_c), 32'd12);
    idle(); do_read(5); cycle();
    idle(); do_read(7); cycle();
    idle(); cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
- Parametrised simple-dual-port RAM: one write port, one read port, one clock.
- Successor to the single-port RAM. Adds per-byte write enables, selectable read latency (1 or 2 cycles) and a read-valid strobe.
- Adds a defined read-during-write collision policy and an optional hardware clear sweep after reset.
- Used as register-file, data-memory and buffer storage in the pipelined CPU.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8 (elaboration error otherwise).
- NUM_WORDS, 256, number of words; must be >= 2 (need not be a power of two).
- ADDR_W, $clog2(NUM_WORDS), address width.
- BE_W, DATA_W/8, number of byte-enable bits.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2 (elaboration error otherwise).
- RDW_MODE, 1, read-during-write policy: 1 = write-first (bypass), 0 = read-first (old data).
- INIT_CLEAR, 1, 1 = zero the whole array after reset before accepting traffic.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous assert, active-high.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  BE_W  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  one-cycle strobe: rd_data holds the result of a read.
- init_busy  out  1  high while the clear sweep runs.

Behaviour:
- Clock/reset (already decided): single clock clk; reset rst is asynchronous and active-high.
- Reset values: rd_data = 0, rd_valid = 0, read pipeline valid bits = 0, init counter = 0, init_busy = INIT_CLEAR.
- Reset does not alter array contents except through the clear sweep that follows.
- FSM states: INIT, READY.
  - Reset enters INIT if INIT_CLEAR = 1, else READY.
  - INIT: each cycle writes 0 to mem[cnt], then cnt++. When cnt = NUM_WORDS-1 is written, go to READY.
  - The sweep lasts exactly NUM_WORDS cycles after reset deassertion.
  - In READY, init_busy = 0.
  - Reset asserted mid-sweep returns to INIT with cnt = 0; the sweep restarts from address 0.
- During INIT, wr_en and rd_en are ignored: no user write occurs and no rd_valid is generated.
- Write: in READY, if wr_en, then for each i with wr_be[i] = 1, byte i of mem[wr_addr] is replaced on the clock edge. Other bytes keep their value. wr_be = 0 is a no-op.
- Read:
  - rd_en sampled high at edge t gives rd_valid = 1 and valid rd_data at edge t+RD_LATENCY.
  - Back-to-back reads are fully pipelined, one result per cycle.
  - With RD_LATENCY = 2, the second stage is a plain register with no enable.
- rd_data holds its last value when rd_valid = 0; it never returns to 0 except on reset.
- Collision (rd_en and wr_en in the same cycle, rd_addr = wr_addr):
  - RDW_MODE = 1: returned word = enabled bytes from wr_data, other bytes from old contents.
  - RDW_MODE = 0: returned word = old contents.
  - Either way the memory is updated.
- Out-of-range address (>= NUM_WORDS, non-power-of-two depth only): writes dropped, reads return 0 with rd_valid = 1.
- rd_en or wr_en with X/unknown address is not supported; the bench asserts against it.

Decomposition:
- Package ram_pkg:
  - rdw_mode_e enum: RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1.
  - init_state_e enum: INIT, READY.
  - Function be_merge(old, new, be) returning the byte-merged word; shared with other byte-enable memories.
- One sub-module: ram_init_seq, holding the INIT/READY FSM and address counter. Outputs: init_busy, init_we, init_addr.
- The top muxes init_we/init_addr over the user write port.
- The array, read pipeline and bypass stay in the top module.

Test Plan:
- Clear sweep: INIT_CLEAR = 1, NUM_WORDS = 16.
  - Release rst; init_busy high for exactly 16 cycles; rd_en during the sweep gives no rd_valid.
  - Afterwards, reading every address returns 0.
- Byte enables: write 0xAABBCCDD to addr 5 with be = 4'hF, then 0x11223344 with be = 4'b0101.
  - Read addr 5 returns 0xAA22CC44.
- Latency: RD_LATENCY = 2; rd_en pulses on 3 consecutive cycles at addrs 1, 2, 3 (preloaded 0x1, 0x2, 0x3).
  - rd_valid is high for 3 cycles starting 2 edges later, with data 0x1, 0x2, 0x3.
  - rd_data holds 0x3 afterwards.
- Collision: addr 7 holds 0x00000000; same-cycle write 0xFFFFFFFF with be = 4'b0011 and read of addr 7.
  - RDW_MODE = 1 returns 0x0000FFFF; RDW_MODE = 0 returns 0x00000000.
  - A following read returns 0x0000FFFF in both modes.
- Reset mid-operation: assert rst at sweep cycle 9 while a read is in flight.
  - rd_valid = 0 and rd_data = 0 immediately (asynchronous).
  - The sweep restarts and runs a full 16 cycles.
- Out of range: NUM_WORDS = 12; write 0x5A5A5A5A to addr 13, then read addr 13.
  - rd_valid = 1, rd_data = 0; addrs 0–11 unchanged.
